// File: rtl/configs_loader.sv
// ----------------------------------------------------------------------------
// configs_loader
//
// Streams NUM_WORDS configuration words from a valid/ready source into a
// latch bank. Each word is presented on io_d_out and written into its latch
// with a one-cycle enable pulse. The pulse is framed by a setup cycle and a
// hold cycle, and io_d_out is constant across all three cycles. A word
// therefore takes at least four cycles: LOAD, SETUP, STROBE and HOLD.
//
// Optional feature: define CONFIGS_LOADER_CHECKSUM_EN to add a CHECK state.
// After the last word, this state accepts one extra word and compares it with
// the running sum of all loaded words, modulo 2^WORD_WIDTH. A mismatch sets
// the sticky io_err flag. With the macro undefined, the CHECK state and the
// checksum register are not built, and io_err is tied to 0.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : synchronous, active-low reset
//   io_start       : pulse; starts a load when idle
//   io_abort       : abandons a load in progress
//   io_in_valid    : upstream word valid
//   io_in_ready    : loader accepts io_in_data this cycle
//   io_in_data     : upstream config word
//   io_d_out       : data bus to the latch bank
//   io_configs_en  : one-hot-or-zero latch enables
//   io_busy        : load in progress
//   io_done        : sticky, last load completed
//   io_err         : sticky checksum mismatch (checksum build only)
// ----------------------------------------------------------------------------
module configs_loader #(
    parameter int NUM_WORDS  = 40,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_start,
    input  logic                  io_abort,
    input  logic                  io_in_valid,
    output logic                  io_in_ready,
    input  logic [WORD_WIDTH-1:0] io_in_data,
    output logic [WORD_WIDTH-1:0] io_d_out,
    output logic [NUM_WORDS-1:0]  io_configs_en,
    output logic                  io_busy,
    output logic                  io_done,
    output logic                  io_err
);

    localparam int INDEX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        HOLD   = 3'd4,
        CHECK  = 3'd5
`else
        HOLD   = 3'd4
`endif
    } state_t;

    state_t                state_reg;
    logic [INDEX_W-1:0]    index_reg;
    logic [WORD_WIDTH-1:0] d_out_reg;
    logic [NUM_WORDS-1:0]  en_reg;
    logic                  ready_reg;
    logic                  busy_reg;
    logic                  done_reg;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
    logic                  err_reg;
    logic [WORD_WIDTH-1:0] checksum_reg;
`endif

    // One-hot decode of the current word index. It is loaded into en_reg
    // only on the SETUP->STROBE edge, so the bank sees a single clean pulse.
    logic [NUM_WORDS-1:0] strobe_sel;

    generate
        for (genvar gi = 0; gi < NUM_WORDS; gi++) begin : g_sel
            assign strobe_sel[gi] = (index_reg == INDEX_W'(gi));
        end
    endgenerate

    // ready_reg is high only in LOAD (and in CHECK), so this term is the
    // handshake for whichever of those states is active.
    logic in_accept;
    assign in_accept = io_in_valid && ready_reg;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            index_reg    <= '0;
            d_out_reg    <= '0;
            en_reg       <= '0;
            ready_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
            err_reg      <= 1'b0;
            checksum_reg <= '0;
`endif
        end else if (io_abort && (state_reg != IDLE)) begin
            // Abort wins over the handshake and over start.
            // io_d_out is deliberately left holding its last word.
            state_reg <= IDLE;
            en_reg    <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io_start) begin
                        state_reg    <= LOAD;
                        index_reg    <= '0;
                        ready_reg    <= 1'b1;
                        busy_reg     <= 1'b1;
                        done_reg     <= 1'b0;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
                        err_reg      <= 1'b0;
                        checksum_reg <= '0;
`endif
                    end
                end

                LOAD: begin
                    if (in_accept) begin
                        d_out_reg    <= io_in_data;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
                        checksum_reg <= checksum_reg + io_in_data;
`endif
                        ready_reg    <= 1'b0;
                        state_reg    <= SETUP;
                    end
                end

                SETUP: begin
                    en_reg    <= strobe_sel;
                    state_reg <= STROBE;
                end

                STROBE: begin
                    en_reg    <= '0;
                    state_reg <= HOLD;
                end

                HOLD: begin
                    if (index_reg == LAST_INDEX) begin
`ifdef CONFIGS_LOADER_CHECKSUM_EN
                        state_reg <= CHECK;
                        ready_reg <= 1'b1;
`else
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
`endif
                    end else begin
                        index_reg <= index_reg + INDEX_W'(1);
                        ready_reg <= 1'b1;
                        state_reg <= LOAD;
                    end
                end

`ifdef CONFIGS_LOADER_CHECKSUM_EN
                CHECK: begin
                    // The check word is consumed without a strobe.
                    // io_d_out keeps the last config word.
                    if (in_accept) begin
                        err_reg   <= (io_in_data != checksum_reg);
                        ready_reg <= 1'b0;
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
`endif

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign io_in_ready   = ready_reg;
    assign io_d_out      = d_out_reg;
    assign io_configs_en = en_reg;
    assign io_busy       = busy_reg;
    assign io_done       = done_reg;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
    assign io_err        = err_reg;
`else
    assign io_err        = 1'b0;
`endif

endmodule

// File: tb/tb_configs_loader.sv
// ----------------------------------------------------------------------------
// tb_configs_loader
//
// Self-checking bench for configs_loader.
// The driver pushes {index, data} into a scoreboard when a word is accepted.
// The monitor pops one entry per enable pulse and compares the decoded enable
// index and the data bus against it. It also checks io_d_out stability around
// each pulse, the one-cycle pulse width, and the completion cycle.
// ----------------------------------------------------------------------------
module tb_configs_loader;

    localparam int NW = 40;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_start;
    logic          io_abort;
    logic          io_in_valid;
    logic          io_in_ready;
    logic [WW-1:0] io_in_data;
    logic [WW-1:0] io_d_out;
    logic [NW-1:0] io_configs_en;
    logic          io_busy;
    logic          io_done;
    logic          io_err;

    always #5 clk = ~clk;

    configs_loader #(.NUM_WORDS(NW), .WORD_WIDTH(WW)) dut (
        .clk           (clk),
        .reset         (reset),
        .io_start      (io_start),
        .io_abort      (io_abort),
        .io_in_valid   (io_in_valid),
        .io_in_ready   (io_in_ready),
        .io_in_data    (io_in_data),
        .io_d_out      (io_d_out),
        .io_configs_en (io_configs_en),
        .io_busy       (io_busy),
        .io_done       (io_done),
        .io_err        (io_err)
    );

    typedef struct {
        int            idx;
        logic [WW-1:0] data;
    } exp_t;

    exp_t sb[$];

    int checks       = 0;
    int failures     = 0;
    int cyc          = 0;
    int start_cyc    = 0;
    int exp_done_cyc = 0;
    bit mon_on       = 1'b0;
    bit timing_chk   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [NW-1:0] v);
        for (int i = 0; i < NW; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------------------------------------------------------- monitor
    logic [NW-1:0] prev_en;
    logic [WW-1:0] prev_d;
    logic          prev_done;
    exp_t          mon_e;

    always @(negedge clk) begin
        if (mon_on) begin
            if (io_configs_en != '0) begin
                check_val("en_onehot", 64'($onehot(io_configs_en)), 64'd1);
                check_val("strobe_stable", io_d_out, prev_d);
                check_val("ready_in_strobe", io_in_ready, 1'b0);
                if (sb.size() == 0) begin
                    check_val("unexpected_strobe", idx_of(io_configs_en), -1);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("en_index", idx_of(io_configs_en), mon_e.idx);
                    check_val("strobe_data", io_d_out, mon_e.data);
                end
            end
            if (prev_en != '0) begin
                check_val("pulse_width", io_configs_en, '0);
                check_val("hold_stable", io_d_out, prev_d);
            end
            if (timing_chk && io_done && !prev_done)
                check_val("done_cycle", cyc - start_cyc, exp_done_cyc);
        end
        prev_en   <= io_configs_en;
        prev_d    <= io_d_out;
        prev_done <= io_done;
    end

    // ----------------------------------------------------------------- driver
    // All driver tasks are entered and left just after a falling edge.
    task automatic pulse_start();
        io_start = 1'b1;
        if (!io_busy) start_cyc = cyc + 1;
        @(negedge clk);
        io_start = 1'b0;
        check_val("start_busy", io_busy, 1'b1);
        check_val("start_done_clr", io_done, 1'b0);
    endtask

    task automatic send_word(input logic [WW-1:0] d, input int idx, input bit rnd, input bit push);
        int budget = 200;
        io_in_data = d;
        while (budget > 0) begin
            io_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (io_in_valid && io_in_ready) begin
                if (push) sb.push_back('{idx, d});
                @(negedge clk);
                return;
            end
            @(negedge clk);
            budget--;
        end
        check_val("accept_timeout", 0, 1);
    endtask

    task automatic wait_done(input logic [WW-1:0] last, input bit exp_err);
        int b = 0;
        while (!io_done && b < 50) begin
            @(negedge clk);
            b++;
        end
        check_val("done", io_done, 1'b1);
        check_val("done_busy", io_busy, 1'b0);
        check_val("done_ready", io_in_ready, 1'b0);
        check_val("done_en", io_configs_en, '0);
        check_val("done_d_out", io_d_out, last);
        check_val("done_err", io_err, exp_err);
        check_val("sb_left", sb.size(), 0);
    endtask

    // mode 0: 0x1000_0000+i, mode 1: random words, mode 2: all ones (value 1)
    task automatic run_load(input int mode, input bit rnd, input logic [WW-1:0] chk_delta, input bit exp_err);
        logic [WW-1:0] d;
        logic [WW-1:0] sum;
        logic [WW-1:0] last;
        sum  = '0;
        last = '0;
        pulse_start();
        for (int i = 0; i < NW; i++) begin
            if (mode == 0)      d = 32'h1000_0000 + 32'(i);
            else if (mode == 1) d = $urandom;
            else                d = 32'h0000_0001;
            sum  = sum + d;
            last = d;
            send_word(d, i, rnd, 1'b1);
        end
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        send_word(sum + chk_delta, -1, rnd, 1'b0);
`else
        if (chk_delta != '0) $display("note: no check word in this build");
`endif
        io_in_valid = 1'b0;
        wait_done(last, exp_err);
        $display("load mode=%0d rnd=%0d sum=0x%08h done=%0b err=%0b", mode, rnd, sum, io_done, io_err);
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        reset       = 1'b0;
        io_start    = 1'b0;
        io_abort    = 1'b0;
        io_in_valid = 1'b0;
        io_in_data  = '0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check_val("rst_d_out", io_d_out, '0);
        check_val("rst_en", io_configs_en, '0);
        check_val("rst_ready", io_in_ready, 1'b0);
        check_val("rst_busy", io_busy, 1'b0);
        check_val("rst_done", io_done, 1'b0);
        check_val("rst_err", io_err, 1'b0);
        $display("reset released");
        mon_on = 1'b1;

        // Back-to-back stream: completion lands 4*NW cycles after start
        // (one more in the checksum build for the check word).
        timing_chk = 1'b1;
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        exp_done_cyc = 4 * NW + 1;
`else
        exp_done_cyc = 4 * NW;
`endif
        run_load(0, 1'b0, '0, 1'b0);
        timing_chk = 1'b0;

        // Random valid gaps, random data.
        run_load(1, 1'b1, '0, 1'b0);

        // Abort in the HOLD cycle after word 17 is strobed.
        pulse_start();
        for (int i = 0; i < 18; i++) send_word(32'h2000_0000 + 32'(i), i, 1'b0, 1'b1);
        io_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        io_abort = 1'b1;
        @(negedge clk);
        io_abort = 1'b0;
        check_val("abort_en", io_configs_en, '0);
        check_val("abort_busy", io_busy, 1'b0);
        check_val("abort_done", io_done, 1'b0);
        check_val("abort_ready", io_in_ready, 1'b0);
        check_val("abort_d_out", io_d_out, 32'h2000_0011);
        repeat (3) @(negedge clk);
        check_val("abort_idle_ready", io_in_ready, 1'b0);
        $display("abort after word 17 handled");
        run_load(0, 1'b0, '0, 1'b0);

        // A start pulse during word 5 is ignored; a reset during word 20 ends the load.
        pulse_start();
        for (int i = 0; i < 6; i++) send_word(32'h3000_0000 + 32'(i), i, 1'b0, 1'b1);
        io_in_valid = 1'b0;
        io_start    = 1'b1;
        @(negedge clk);
        io_start = 1'b0;
        for (int i = 6; i < 21; i++) send_word(32'h3000_0000 + 32'(i), i, 1'b0, 1'b1);
        io_in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        sb.delete();
        check_val("mid_rst_busy", io_busy, 1'b0);
        check_val("mid_rst_d_out", io_d_out, '0);
        check_val("mid_rst_done", io_done, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("post_rst_en", io_configs_en, '0);
        end
        $display("mid-load start ignored, reset at word 20 handled");

        // All-ones stream: checksum 0x28 matches, 0x29 does not.
        run_load(2, 1'b0, '0, 1'b0);
`ifdef CONFIGS_LOADER_CHECKSUM_EN
        run_load(2, 1'b0, 32'h1, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
